sdrx_word_buffer: RTL and testbench

- Downstream consumer of the SD receive-frame stage: accepts its byte stream (byte/write strobe) and end-of-frame done/error pulses.
- Packs bytes big-endian into 32-bit words and writes them into an internal block-RAM buffer.
- Tracks byte count and frame status, and provides a registered read port from which the bus side drains the received block.

---
 rtl/sdrx_word_buffer_pkg.sv | 34 +++
 rtl/sdrx_word_buffer_if.sv | 30 +++
 rtl/sdrx_bram.sv | 42 ++++
 rtl/sdrx_word_buffer.sv | 189 ++++++++++++++++++
 tb/tb_sdrx_word_buffer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdrx_word_buffer_pkg.sv
// sdrx_word_buffer_pkg: shared definitions for the SD receive word buffer.
//   state_t    - buffer controller states
//   WORD_W     - width of one stored word
//   place_byte - drops a byte into its lane of a 32-bit assembly word
package sdrx_word_buffer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Big-endian puts lane 0 in the top byte; little-endian puts it in the bottom byte.
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                    input logic [7:0]        data,
                                                    input logic [1:0]        lane,
                                                    input logic              little);
    logic [WORD_W-1:0] w;
    logic [4:0]        shift;
    w = word;
    if (little) begin
      shift = {lane, 3'b000};
    end else begin
      shift = {~lane, 3'b000};
    end
    w[shift +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/sdrx_word_buffer_if.sv
// sdrx_word_buffer_if: byte stream from the frame stage plus the word read port.
//   i_byte/i_wr       - received byte and its strobe
//   i_done/i_err      - end-of-frame pulses (good / bad CRC)
//   i_rd_stb/addr     - read request and word address
//   o_rd_data/valid   - registered read data, valid one cycle after the strobe
// master: the side driving bytes and reads; slave: the buffer.
interface sdrx_word_buffer_if
  import sdrx_word_buffer_pkg::*;
#(
  parameter int LGMEM = 10
);
  logic [7:0]        i_byte;
  logic              i_wr;
  logic              i_done;
  logic              i_err;
  logic              i_rd_stb;
  logic [LGMEM-1:0]  i_rd_addr;
  logic [WORD_W-1:0] o_rd_data;
  logic              o_rd_valid;

  modport master (
    output i_byte, i_wr, i_done, i_err, i_rd_stb, i_rd_addr,
    input  o_rd_data, o_rd_valid
  );

  modport slave (
    input  i_byte, i_wr, i_done, i_err, i_rd_stb, i_rd_addr,
    output o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/sdrx_bram.sv
// sdrx_bram: simple dual-port RAM, 2^LGMEM x DW, one write port and one
// registered read-first read port. Only the read output registers reset.
//   clk, reset        - clock, synchronous active-high reset
//   we, waddr, wdata  - write port
//   rd_stb, raddr     - read request
//   rd_data, rd_valid - read data and valid, one cycle after rd_stb
module sdrx_bram #(
  parameter int LGMEM = 10,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [LGMEM-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             rd_stb,
  input  logic [LGMEM-1:0] raddr,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid
);
  logic [DW-1:0] mem_r [0:(1<<LGMEM)-1];

  // Write port; kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port; a same-cycle write to the read address yields the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= {DW{1'b0}};
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_stb;
      if (rd_stb) begin
        rd_data <= mem_r[raddr];
      end
    end
  end
endmodule

// File: rtl/sdrx_word_buffer.sv
// sdrx_word_buffer: packs received SD bytes into 32-bit words and stores them
// in an internal RAM, tracking byte count and frame status.
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_start        - arm a new transfer (clears pointers and flags)
//   bus            - byte stream, end-of-frame pulses and word read port
//   o_busy         - armed or flushing
//   o_complete     - frame stored with good CRC (sticky)
//   o_crc_err      - bad CRC seen while armed/flushing (sticky)
//   o_overflow     - byte arrived with the buffer full (sticky)
//   o_count        - bytes accepted in this transfer
module sdrx_word_buffer
  import sdrx_word_buffer_pkg::*;
#(
  parameter int LGMEM             = 10,
  parameter int OPT_LITTLE_ENDIAN = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  sdrx_word_buffer_if.slave  bus,
  output logic               o_busy,
  output logic               o_complete,
  output logic               o_crc_err,
  output logic               o_overflow,
  output logic [LGMEM+2:0]   o_count
);
  localparam logic [LGMEM:0]   WPTR_FULL = {1'b1, {LGMEM{1'b0}}};
  localparam logic [LGMEM:0]   WPTR_ONE  = {{LGMEM{1'b0}}, 1'b1};
  localparam logic [LGMEM+2:0] COUNT_MAX = {1'b1, {(LGMEM+2){1'b0}}};
  localparam logic [LGMEM+2:0] COUNT_ONE = {{(LGMEM+2){1'b0}}, 1'b1};
  localparam logic             LITTLE    = (OPT_LITTLE_ENDIAN != 0);

  state_t             state_r, state_next_s;
  logic [1:0]         lane_r, lane_next_s;
  logic [LGMEM:0]     wptr_r, wptr_next_s;
  logic [LGMEM+2:0]   count_r, count_next_s;
  logic [WORD_W-1:0]  asm_r, asm_next_s, word_s;
  logic               we_r, we_next_s;
  logic [WORD_W-1:0]  wdata_r, wdata_next_s;
  logic [LGMEM-1:0]   waddr_r, waddr_next_s;
  logic               busy_r, complete_r, crc_err_r, overflow_r;
  logic               complete_next_s, crc_err_next_s, overflow_next_s;

  // Next-state and datapath: a byte is absorbed before done/err is judged.
  always_comb begin
    state_next_s    = state_r;
    lane_next_s     = lane_r;
    wptr_next_s     = wptr_r;
    count_next_s    = count_r;
    asm_next_s      = asm_r;
    we_next_s       = 1'b0;
    wdata_next_s    = wdata_r;
    waddr_next_s    = waddr_r;
    complete_next_s = complete_r;
    crc_err_next_s  = crc_err_r;
    overflow_next_s = overflow_r;
    word_s          = place_byte(asm_r, bus.i_byte, lane_r, LITTLE);

    if (i_start) begin
      state_next_s    = ST_ARMED;
      lane_next_s     = 2'd0;
      wptr_next_s     = {(LGMEM+1){1'b0}};
      count_next_s    = {(LGMEM+3){1'b0}};
      asm_next_s      = {WORD_W{1'b0}};
      complete_next_s = 1'b0;
      crc_err_next_s  = 1'b0;
      overflow_next_s = 1'b0;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (bus.i_wr && (wptr_r == WPTR_FULL)) begin
            overflow_next_s = 1'b1;
            state_next_s    = ST_ERROR;
          end else begin
            if (bus.i_wr) begin
              if (count_r != COUNT_MAX) begin
                count_next_s = count_r + COUNT_ONE;
              end else begin
                count_next_s = count_r;
              end
              if (lane_r == 2'd3) begin
                we_next_s    = 1'b1;
                wdata_next_s = word_s;
                waddr_next_s = wptr_r[LGMEM-1:0];
                wptr_next_s  = wptr_r + WPTR_ONE;
                lane_next_s  = 2'd0;
                asm_next_s   = {WORD_W{1'b0}};
              end else begin
                lane_next_s  = lane_r + 2'd1;
                asm_next_s   = word_s;
              end
            end else begin
              asm_next_s = asm_r;
            end
            // Error wins when both end-of-frame pulses arrive together.
            if (bus.i_err) begin
              crc_err_next_s = 1'b1;
              state_next_s   = ST_ERROR;
            end else if (bus.i_done) begin
              if (lane_next_s == 2'd0) begin
                complete_next_s = 1'b1;
                state_next_s    = ST_DONE;
              end else begin
                state_next_s    = ST_FLUSH;
              end
            end else begin
              state_next_s = ST_ARMED;
            end
          end
        end
        ST_FLUSH: begin
          if (bus.i_err) begin
            crc_err_next_s = 1'b1;
            state_next_s   = ST_ERROR;
          end else begin
            // Unfilled lanes of asm_r are still zero from the last wrap/arm.
            we_next_s       = 1'b1;
            wdata_next_s    = asm_r;
            waddr_next_s    = wptr_r[LGMEM-1:0];
            wptr_next_s     = wptr_r + WPTR_ONE;
            lane_next_s     = 2'd0;
            asm_next_s      = {WORD_W{1'b0}};
            complete_next_s = 1'b1;
            state_next_s    = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: begin
          state_next_s = state_r;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      lane_r     <= 2'd0;
      wptr_r     <= {(LGMEM+1){1'b0}};
      count_r    <= {(LGMEM+3){1'b0}};
      asm_r      <= {WORD_W{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {WORD_W{1'b0}};
      waddr_r    <= {LGMEM{1'b0}};
      busy_r     <= 1'b0;
      complete_r <= 1'b0;
      crc_err_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      lane_r     <= lane_next_s;
      wptr_r     <= wptr_next_s;
      count_r    <= count_next_s;
      asm_r      <= asm_next_s;
      we_r       <= we_next_s;
      wdata_r    <= wdata_next_s;
      waddr_r    <= waddr_next_s;
      busy_r     <= (state_next_s == ST_ARMED) || (state_next_s == ST_FLUSH);
      complete_r <= complete_next_s;
      crc_err_r  <= crc_err_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  // Completed words are written one clock after the byte that finished them.
  sdrx_bram #(
    .LGMEM (LGMEM),
    .DW    (WORD_W)
  ) u_bram (
    .clk      (i_clk),
    .reset    (i_reset),
    .we       (we_r),
    .waddr    (waddr_r),
    .wdata    (wdata_r),
    .rd_stb   (bus.i_rd_stb),
    .raddr    (bus.i_rd_addr),
    .rd_data  (bus.o_rd_data),
    .rd_valid (bus.o_rd_valid)
  );

  assign o_busy     = busy_r;
  assign o_complete = complete_r;
  assign o_crc_err  = crc_err_r;
  assign o_overflow = overflow_r;
  assign o_count    = count_r;
endmodule

// File: tb/tb_sdrx_word_buffer.sv
// tb_sdrx_word_buffer: directed scenarios plus randomized frames checked
// against a byte-queue model. DUT a uses LGMEM=10, DUT b uses LGMEM=2.
module tb_sdrx_word_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, comp_a, crc_a, ovf_a;
  logic busy_b, comp_b, crc_b, ovf_b;
  logic [12:0] count_a;
  logic [4:0]  count_b;
  int n_cmp = 0;
  int n_fail = 0;

  sdrx_word_buffer_if #(.LGMEM(10)) ifa();
  sdrx_word_buffer_if #(.LGMEM(2))  ifb();

  sdrx_word_buffer #(.LGMEM(10), .OPT_LITTLE_ENDIAN(0)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start_a), .bus(ifa),
    .o_busy(busy_a), .o_complete(comp_a), .o_crc_err(crc_a),
    .o_overflow(ovf_a), .o_count(count_a)
  );

  sdrx_word_buffer #(.LGMEM(2), .OPT_LITTLE_ENDIAN(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start_b), .bus(ifb),
    .o_busy(busy_b), .o_complete(comp_b), .o_crc_err(crc_b),
    .o_overflow(ovf_b), .o_count(count_b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] b);
    ifa.i_wr = 1'b1;
    ifa.i_byte = b;
    tick();
    ifa.i_wr = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    ifb.i_wr = 1'b1;
    ifb.i_byte = b;
    tick();
    ifb.i_wr = 1'b0;
  endtask

  task automatic read_a(input logic [9:0] addr, output logic [31:0] data, output logic valid);
    ifa.i_rd_stb = 1'b1;
    ifa.i_rd_addr = addr;
    tick();
    ifa.i_rd_stb = 1'b0;
    data = ifa.o_rd_data;
    valid = ifa.o_rd_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if ({busy_a, comp_a, crc_a, ovf_a} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags_a got %b want 0000", {busy_a, comp_a, crc_a, ovf_a}); end
    n_cmp++; if (count_a !== 13'd0) begin n_fail++; $display("FAIL reset_count_a got %0d want 0", count_a); end
    n_cmp++; if ({ifa.o_rd_valid, ifa.o_rd_data} !== 33'd0) begin n_fail++; $display("FAIL reset_rd_a got %b/%h want 0/0", ifa.o_rd_valid, ifa.o_rd_data); end
    n_cmp++; if ({busy_b, comp_b, crc_b, ovf_b, count_b} !== 9'd0) begin n_fail++; $display("FAIL reset_b got %b want 0", {busy_b, comp_b, crc_b, ovf_b, count_b}); end
    // Idle ignores bytes and end-of-frame pulses.
    ifa.i_done = 1'b1;
    send_a(8'h5A);
    ifa.i_done = 1'b0;
    tick();
    n_cmp++; if ({busy_a, comp_a, count_a} !== 15'd0) begin n_fail++; $display("FAIL idle_ignore got busy=%b comp=%b cnt=%0d want 0", busy_a, comp_a, count_a); end
  endtask

  task automatic test_512;
    logic [31:0] d;
    logic v;
    start_pulse_a();
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL arm_busy got %b want 1", busy_a); end
    for (int i = 0; i < 512; i++) send_a(8'(i));
    ifa.i_done = 1'b1;
    tick();
    ifa.i_done = 1'b0;
    tick();
    n_cmp++; if ({busy_a, comp_a, crc_a} !== 3'b010) begin n_fail++; $display("FAIL f512_flags got %b want 010", {busy_a, comp_a, crc_a}); end
    n_cmp++; if (count_a !== 13'd512) begin n_fail++; $display("FAIL f512_count got %0d want 512", count_a); end
    read_a(10'd0, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h00010203) begin n_fail++; $display("FAIL f512_mem0 got %b/%h want 1/00010203", v, d); end
    read_a(10'd127, d, v);
    n_cmp++; if (d !== 32'hFCFDFEFF) begin n_fail++; $display("FAIL f512_mem127 got %h want FCFDFEFF", d); end
    read_a(10'd64, d, v);
    n_cmp++; if (d !== 32'h00010203) begin n_fail++; $display("FAIL f512_mem64 got %h want 00010203", d); end
  endtask

  task automatic test_flush;
    logic [31:0] d;
    logic v;
    logic [7:0] pat [6];
    pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    start_pulse_a();
    for (int i = 0; i < 6; i++) send_a(pat[i]);
    ifa.i_done = 1'b1;
    tick();
    ifa.i_done = 1'b0;
    n_cmp++; if ({busy_a, comp_a} !== 2'b10) begin n_fail++; $display("FAIL flush_cycle got busy/comp %b want 10", {busy_a, comp_a}); end
    tick();
    n_cmp++; if ({busy_a, comp_a} !== 2'b01) begin n_fail++; $display("FAIL flush_done got busy/comp %b want 01", {busy_a, comp_a}); end
    n_cmp++; if (count_a !== 13'd6) begin n_fail++; $display("FAIL flush_count got %0d want 6", count_a); end
    tick();
    read_a(10'd0, d, v);
    n_cmp++; if (d !== 32'hAABBCCDD) begin n_fail++; $display("FAIL flush_mem0 got %h want AABBCCDD", d); end
    read_a(10'd1, d, v);
    n_cmp++; if (d !== 32'hEEFF0000) begin n_fail++; $display("FAIL flush_mem1 got %h want EEFF0000", d); end
  endtask

  task automatic test_crc_err;
    start_pulse_a();
    for (int i = 0; i < 8; i++) send_a(8'(8'h30 + i));
    ifa.i_err = 1'b1;
    tick();
    ifa.i_err = 1'b0;
    n_cmp++; if ({busy_a, comp_a, crc_a} !== 3'b001) begin n_fail++; $display("FAIL crc_flags got %b want 001", {busy_a, comp_a, crc_a}); end
    send_a(8'h99);
    ifa.i_done = 1'b1;
    tick();
    ifa.i_done = 1'b0;
    n_cmp++; if (count_a !== 13'd8 || comp_a !== 1'b0) begin n_fail++; $display("FAIL crc_after got cnt=%0d comp=%b want 8/0", count_a, comp_a); end
    // done and err together count as an error.
    start_pulse_a();
    send_a(8'h01);
    send_a(8'h02);
    ifa.i_done = 1'b1;
    ifa.i_err = 1'b1;
    tick();
    ifa.i_done = 1'b0;
    ifa.i_err = 1'b0;
    tick();
    n_cmp++; if ({busy_a, comp_a, crc_a} !== 3'b001) begin n_fail++; $display("FAIL done_err_both got %b want 001", {busy_a, comp_a, crc_a}); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 1; i <= 16; i++) send_b(8'(i));
    n_cmp++; if ({ovf_b, busy_b} !== 2'b01 || count_b !== 5'd16) begin n_fail++; $display("FAIL ovf_pre got ovf/busy %b cnt=%0d want 01/16", {ovf_b, busy_b}, count_b); end
    send_b(8'd17);
    n_cmp++; if ({ovf_b, busy_b} !== 2'b10 || count_b !== 5'd16) begin n_fail++; $display("FAIL ovf_hit got ovf/busy %b cnt=%0d want 10/16", {ovf_b, busy_b}, count_b); end
    ifb.i_rd_stb = 1'b1;
    ifb.i_rd_addr = 2'd3;
    tick();
    ifb.i_rd_stb = 1'b0;
    d = ifb.o_rd_data;
    n_cmp++; if (d !== 32'h0D0E0F10) begin n_fail++; $display("FAIL ovf_mem3 got %h want 0D0E0F10", d); end
  endtask

  task automatic test_restart;
    logic [31:0] d;
    logic v;
    start_pulse_a();
    send_a(8'h77);
    send_a(8'h78);
    send_a(8'h79);
    // Restart with a same-cycle byte, which must be ignored.
    start_a = 1'b1;
    send_a(8'h99);
    start_a = 1'b0;
    n_cmp++; if (count_a !== 13'd0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL restart_clear got cnt=%0d busy=%b want 0/1", count_a, busy_a); end
    send_a(8'h11);
    send_a(8'h22);
    send_a(8'h33);
    send_a(8'h44);
    ifa.i_done = 1'b1;
    tick();
    ifa.i_done = 1'b0;
    tick();
    n_cmp++; if (count_a !== 13'd4 || comp_a !== 1'b1) begin n_fail++; $display("FAIL restart_done got cnt=%0d comp=%b want 4/1", count_a, comp_a); end
    read_a(10'd0, d, v);
    n_cmp++; if (d !== 32'h11223344) begin n_fail++; $display("FAIL restart_mem0 got %h want 11223344", d); end
  endtask

  task automatic test_read_collision;
    start_pulse_a();
    send_a(8'h55);
    send_a(8'h66);
    send_a(8'h77);
    send_a(8'h88);
    // Word 0 is written at the next edge; a read sampled there sees the old word.
    ifa.i_rd_stb = 1'b1;
    ifa.i_rd_addr = 10'd0;
    tick();
    n_cmp++; if (ifa.o_rd_valid !== 1'b1 || ifa.o_rd_data !== 32'h11223344) begin n_fail++; $display("FAIL collide_old got %b/%h want 1/11223344", ifa.o_rd_valid, ifa.o_rd_data); end
    tick();
    ifa.i_rd_stb = 1'b0;
    n_cmp++; if (ifa.o_rd_data !== 32'h55667788) begin n_fail++; $display("FAIL collide_new got %h want 55667788", ifa.o_rd_data); end
    tick();
    n_cmp++; if (ifa.o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop got %b want 0", ifa.o_rd_valid); end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic [31:0] exp_w, d;
    logic v;
    int n, nw, use_err, together;
    for (int f = 0; f < 20; f++) begin
      q.delete();
      n = $urandom_range(1, 40);
      use_err = ($urandom_range(0, 3) == 0) ? 1 : 0;
      together = $urandom_range(0, 1);
      start_pulse_a();
      for (int i = 0; i < n; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        q.push_back(8'($urandom));
        if (i == n - 1 && together == 1) begin
          ifa.i_err = (use_err == 1);
          ifa.i_done = (use_err == 0);
        end
        send_a(q[i]);
        ifa.i_err = 1'b0;
        ifa.i_done = 1'b0;
      end
      if (together == 0) begin
        ifa.i_err = (use_err == 1);
        ifa.i_done = (use_err == 0);
        tick();
        ifa.i_err = 1'b0;
        ifa.i_done = 1'b0;
      end
      tick();
      tick();
      tick();
      n_cmp++;
      if (count_a !== 13'(n) || busy_a !== 1'b0 || comp_a !== (use_err == 0) || crc_a !== (use_err == 1)) begin
        n_fail++;
        $display("FAIL rand_status frame %0d got cnt=%0d busy=%b comp=%b crc=%b want cnt=%0d err=%0d", f, count_a, busy_a, comp_a, crc_a, n, use_err);
      end
      nw = (use_err == 1) ? n / 4 : (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
        exp_w = 32'd0;
        for (int k = 0; k < 4; k++) begin
          if (4 * w + k < n) exp_w = exp_w | (32'(q[4 * w + k]) << (24 - 8 * k));
        end
        read_a(10'(w), d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== exp_w) begin
          n_fail++;
          $display("FAIL rand_word frame %0d word %0d got %b/%h want 1/%h", f, w, v, d, exp_w);
        end
      end
    end
  endtask

  initial begin
    ifa.i_byte = 8'd0; ifa.i_wr = 1'b0; ifa.i_done = 1'b0; ifa.i_err = 1'b0;
    ifa.i_rd_stb = 1'b0; ifa.i_rd_addr = 10'd0;
    ifb.i_byte = 8'd0; ifb.i_wr = 1'b0; ifb.i_done = 1'b0; ifb.i_err = 1'b0;
    ifb.i_rd_stb = 1'b0; ifb.i_rd_addr = 2'd0;
    test_reset();
    test_512();
    test_flush();
    test_crc_err();
    test_overflow();
    test_restart();
    test_read_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
